// File: rtl/apb_requester.sv
// apb_requester: converts a valid/ready request/response channel into single
// APB3/APB4 transfers, one outstanding at a time.
//
// Optional feature: define APB_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYC cycles. A transfer that hits the bound completes with rsp_err = 1
// and rsp_rdata = 0. Without the macro, ACCESS waits for pready indefinitely.
//
// Ports:
//   clk, rstn                    clock (rising edge), async active-low reset
//   req_valid/req_ready          request handshake
//   req_addr/write/wstrb/wdata   request payload
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_err           response payload (rdata is 0 for writes)
//   psel/penable/pwrite          APB control
//   paddr/pstrb/pwdata           APB address, strobes, write data (registered)
//   prdata/pslverr/pready        APB completer status
module apb_requester #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [3:0]  pstrb,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pslverr,
    input  logic        pready
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    // Holds req_ready low during reset even though the state register is IDLE.
    logic        ready_en_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  strb_q;
    logic        write_q, err_q;

    logic        accept;
    logic        capture;
    logic        cap_err;
    logic [31:0] cap_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;
    logic [CntW-1:0] cnt_q;
    logic            timed_out;

    assign timed_out = (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (state_q == StSetup) begin
            cnt_q <= '0;
        end else if (state_q == StAccess && !pready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        cap_err   = 1'b0;
        cap_rdata = 32'h0;
        unique case (state_q)
            StIdle: begin
                req_ready = ready_en_q;
                if (req_valid && ready_en_q) begin
                    accept  = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                psel    = 1'b1;
                state_d = StAccess;
            end
            StAccess: begin
                psel    = 1'b1;
                penable = 1'b1;
                // pready wins over a timeout landing on the same cycle.
                if (pready) begin
                    capture   = 1'b1;
                    cap_err   = pslverr;
                    cap_rdata = write_q ? 32'h0 : prdata;
                    state_d   = StResp;
                end
`ifdef APB_TIMEOUT_EN
                else if (timed_out) begin
                    capture   = 1'b1;
                    cap_err   = 1'b1;
                    cap_rdata = 32'h0;
                    state_d   = StResp;
                end
`endif
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
            addr_q     <= 32'h0;
            write_q    <= 1'b0;
            strb_q     <= 4'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (accept) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                // Reads carry no strobes on APB4.
                strb_q  <= req_write ? req_wstrb : 4'h0;
                wdata_q <= req_wdata;
            end
            if (capture) begin
                rdata_q <= cap_rdata;
                err_q   <= cap_err;
            end
        end
    end

    assign paddr     = addr_q;
    assign pwrite    = write_q;
    assign pstrb     = strb_q;
    assign pwdata    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_requester.sv
module tb_apb_requester;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_write = 1'b0;
    logic [3:0]  req_wstrb = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata = 32'h0;
    logic        pslverr = 1'b0;
    logic        pready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    apb_requester #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata),
        .prdata(prdata), .pslverr(pslverr), .pready(pready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a transfer is SETUP, then (waits+1) ACCESS cycles, then RESP.
    // The response is derived only from the request kind and what the completer returned.
    task automatic xfer(input logic [31:0] a, input logic wr, input logic [3:0] st,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd,
                        input logic slverr, input int hold);
        logic [3:0]  e_strb;
        logic [31:0] e_rdata;
        e_strb  = wr ? st : 4'h0;
        e_rdata = wr ? 32'h0 : rd;
        check("idle_req_ready", req_ready, 1);
        check("idle_psel", psel, 0);
        req_valid = 1'b1; req_addr = a; req_write = wr; req_wstrb = st; req_wdata = wd;
        @(negedge clk);
        // Request inputs must be ignored from here on.
        req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom);
        req_wstrb = 4'($urandom); req_wdata = $urandom;
        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
        check("setup_req_ready", req_ready, 0);
        check("setup_paddr", paddr, a);
        check("setup_pwrite", pwrite, wr);
        check("setup_pstrb", pstrb, e_strb);
        if (wr) check("setup_pwdata", pwdata, wd);
        @(negedge clk);
        for (int w = 0; w <= waits; w++) begin
            check("access_psel", psel, 1);
            check("access_penable", penable, 1);
            check("access_rsp_valid", rsp_valid, 0);
            check("access_paddr", paddr, a);
            check("access_pstrb", pstrb, e_strb);
            pready  = (w == waits);
            prdata  = (w == waits) ? rd : $urandom;
            pslverr = (w == waits) ? slverr : 1'($urandom);
            @(negedge clk);
        end
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
        for (int h = 0; h <= hold; h++) begin
            check("resp_valid", rsp_valid, 1);
            check("resp_psel", psel, 0);
            check("resp_penable", penable, 0);
            check("resp_rdata", rsp_rdata, e_rdata);
            check("resp_err", rsp_err, slverr);
            check("resp_req_ready", req_ready, 0);
            rsp_ready = (h == hold);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        int setups[$];
        int acc_cnt;

        // Reset values
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", paddr, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);

        // Zero-wait write
        xfer(32'h0200_4000, 1'b1, 4'hF, 32'h1234_5678, 0, 32'hAAAA_5555, 1'b0, 0);
        // Read with 3 wait states
        xfer(32'h0000_0100, 1'b0, 4'hF, 32'hFFFF_FFFF, 3, 32'hDEAD_BEEF, 1'b0, 0);
        // Error response held for 5 cycles
        xfer(32'h0000_0200, 1'b0, 4'h0, 32'h0, 1, 32'h0BAD_F00D, 1'b1, 5);

        // Randomized transfers
        for (int i = 0; i < 10; i++) begin
            xfer($urandom, 1'($urandom), 4'($urandom), $urandom, int'($urandom_range(0, 3)),
                 $urandom, 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Back-to-back spacing
        req_valid = 1'b1; req_addr = 32'h10; req_write = 1'b1; req_wstrb = 4'h3;
        rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (psel && !penable) setups.push_back(c);
        end
        req_valid = 1'b0;
        for (int c = 0; c < 10 && !req_ready; c++) @(negedge clk);
        rsp_ready = 1'b0; pready = 1'b0;
        check("b2b_spacing", (setups.size() >= 2) ? 32'(setups[1] - setups[0]) : 32'h0, 4);
        check("b2b_drained", req_ready, 1);

        // Reset during ACCESS
        req_valid = 1'b1; req_addr = 32'h44; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_penable", penable, 1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_psel", psel, 0);
        check("async_rst_penable", penable, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_req_ready", req_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rerst_rsp_valid", rsp_valid, 0);
        xfer(32'h0000_0048, 1'b0, 4'h0, 32'h0, 0, 32'h5A5A_A5A5, 1'b0, 0);

`ifdef APB_TIMEOUT_EN
        // Timeout: pready stuck low
        req_valid = 1'b1; req_addr = 32'h80; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; pready = 1'b0;
        acc_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (psel && penable) acc_cnt++;
            else break;
        end
        check("timeout_access_cycles", 32'(acc_cnt), TO);
        check("timeout_rsp_valid", rsp_valid, 1);
        check("timeout_rsp_err", rsp_err, 1);
        check("timeout_rsp_rdata", rsp_rdata, 0);
        check("timeout_psel", psel, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("timeout_idle", req_ready, 1);
`else
        // Without the timeout, ACCESS waits indefinitely
        req_valid = 1'b1; req_addr = 32'h80; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; pready = 1'b0;
        acc_cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (psel && penable) acc_cnt++;
        end
        check("no_timeout_access_cycles", 32'(acc_cnt), 1000);
        check("no_timeout_rsp_valid", rsp_valid, 0);
        pready = 1'b1; prdata = 32'hCAFE_0001; pslverr = 1'b0;
        @(negedge clk);
        pready = 1'b0;
        check("late_ready_rsp_valid", rsp_valid, 1);
        check("late_ready_rdata", rsp_rdata, 32'hCAFE_0001);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("late_ready_idle", req_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
# apb_requester

APB requester (master) that converts a simple valid/ready request/response channel into APB3/APB4 transfers. It drives one transfer at a time toward APB completers such as the interrupt controller and the other peripheral slaves. It sits between a CPU-side or debug-side load/store port and the APB fabric.

## Interface
- TIMEOUT_CYC, 256: ACCESS-phase cycles allowed before a forced error completion. Used only with `APB_TIMEOUT_EN`. Must be ≥2.
- clk  input  1  clock; all logic rising-edge.
- rstn  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when high together with req_valid.
- req_addr  input  32  byte address.
- req_write  input  1  1 = write, 0 = read.
- req_wstrb  input  4  write byte strobes.
- req_wdata  input  32  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when high together with rsp_valid.
- rsp_rdata  output  32  read data; 0 for writes.
- rsp_err  output  1  pslverr or timeout.
- psel, penable, pwrite  output  1  APB control.
- paddr  output  32  APB address.
- pstrb  output  4  APB strobes.
- pwdata  output  32  APB write data.
- prdata  input  32  APB read data.
- pslverr, pready  input  1  APB completer status.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - req_ready = 1. No other state drives req_ready high.
  - On the req_valid handshake, register addr, write, wdata and strobes (strobes forced to 4'b0 for reads, per APB4), then go to SETUP.
- SETUP: psel = 1, penable = 0. Go to ACCESS unconditionally.
- ACCESS:
  - psel = 1, penable = 1.
  - If pready = 1:
    - Capture rsp_err = pslverr.
    - Capture rsp_rdata = prdata for reads, 0 for writes.
    - Go to RESP.
  - If pready = 0, remain in ACCESS.
- RESP:
  - psel = 0, penable = 0, rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until the rsp_ready handshake, then go to IDLE.
- paddr, pwrite, pstrb and pwdata are registered.
  - They are stable from SETUP through the end of ACCESS.
  - They hold their last value in IDLE and RESP; they are not cleared.
- Exactly one outstanding transfer. Request inputs are ignored outside IDLE.
- pslverr and prdata are sampled only on the ACCESS cycle where pready = 1.

## Timing
- Reset values: all outputs 0 (req_ready is 0 during reset and 1 on the first cycle after reset release), state IDLE.
- Reset asserted mid-transfer:
  - psel and penable drop immediately (asynchronous).
  - Any pending response is discarded.
- Zero-wait completer, request handshake at edge N:
  - SETUP during cycle N+1.
  - ACCESS during cycle N+2, with pready sampled at edge N+3.
  - rsp_valid high during cycle N+3.
- Each pready-low cycle in ACCESS adds one cycle of latency.
- If rsp_ready is already high in RESP, IDLE (req_ready = 1) is the next cycle. Minimum request-to-request spacing is 4 cycles.
- rsp_valid never asserts in the same cycle as psel.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - A counter (width clog2(TIMEOUT_CYC)+1) clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - When the count reaches TIMEOUT_CYC-1 and pready is still 0, the FSM goes to RESP with rsp_err = 1 and rsp_rdata = 0, and psel/penable deassert.
  - If pready = 1 on that same cycle, pready wins: normal completion, with pslverr as returned.
- `APB_TIMEOUT_EN` not defined:
  - No counter is built and TIMEOUT_CYC is unused.
  - ACCESS waits for pready indefinitely.

## Test plan
- Zero-wait write: addr 0x0200_4000, wdata 0x1234_5678, wstrb 4'hF, pready = 1 -> psel at N+1, penable at N+2; rsp_valid at N+3 with rsp_err = 0, rsp_rdata = 0.
- Read with 3 wait states: prdata = 0xDEAD_BEEF presented with pready on the 4th ACCESS cycle -> rsp_rdata = 0xDEAD_BEEF, pstrb = 0 throughout, paddr stable throughout.
- Error: pslverr = 1 with pready -> rsp_err = 1. With rsp_ready held 0 for 5 cycles, rsp_valid and the data stay stable and req_ready stays 0.
- Back-to-back: req_valid held high and rsp_ready = 1 -> second SETUP begins exactly 4 cycles after the first.
- Timeout (macro on, TIMEOUT_CYC = 8, pready stuck at 0) -> exactly 8 ACCESS cycles, then rsp_err = 1, rsp_rdata = 0, psel = 0. With the macro off, ACCESS is still held after 1000 cycles.
- Reset asserted during ACCESS -> psel, penable and rsp_valid go to 0 asynchronously; after release the first request completes normally.
